// File: rtl/div_unit_pkg.sv
// Shared ALU definitions for the sequential divider: state encoding,
// iteration count and counter width.
package div_unit_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_ITER  = DIV_WIDTH;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH) + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_t;

endpackage : div_unit_pkg

// File: rtl/div_controller.sv
// One radix-2 restoring step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor and keep the result only if it is non-negative.
module div_controller #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_div,
  input  logic             i_q_in,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_q_bit
);

  logic [WIDTH:0]   w_shifted;
  logic [WIDTH+1:0] w_trial;

  // The extra top bit of the trial is the borrow: set means trial < 0.
  assign w_shifted = {i_rem, i_q_in};
  assign w_trial   = {1'b0, w_shifted} - {2'b00, i_div};

  always_comb begin
    o_q_bit = ~w_trial[WIDTH+1];
    o_rem   = w_shifted[WIDTH-1:0];
    if (o_q_bit) begin
      o_rem = w_trial[WIDTH-1:0];
    end
  end

endmodule : div_controller

// File: rtl/div_unit.sv
// Sequential signed divider: captures operands on start, runs WIDTH restoring
// iterations on magnitudes, then registers sign-corrected quotient/remainder.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] remainder,
  output logic             ready,
  output logic             exception,
  output div_state_t       dbg_state
);

  localparam int CW = $clog2(WIDTH) + 1;

  // Handshake: start is a one-cycle request accepted in any state; ready is
  // high while a finished result is held and drops on the next start or reset.

  div_state_t       r_state;
  div_state_t       w_state_next;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_den;
  logic [WIDTH-1:0] r_dividend;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dz;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_rem_out;
  logic             r_ready;
  logic             r_exc;

  logic             w_last;
  logic             w_iter;
  logic             w_finish;
  logic [WIDTH-1:0] w_rem_next;
  logic             w_q_bit;
  logic [WIDTH-1:0] w_quo_next;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + 1'b1) : v;
  endfunction

  div_controller #(.WIDTH(WIDTH)) u_step (
    .i_rem   (r_rem),
    .i_div   (r_den),
    .i_q_in  (r_quo[WIDTH-1]),
    .o_rem   (w_rem_next),
    .o_q_bit (w_q_bit)
  );

  assign w_quo_next = {r_quo[WIDTH-2:0], w_q_bit};
  assign w_last     = (r_count == CW'(DIV_ITER - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (start) begin
      w_state_next = ST_RUN;
    end else begin
      case (r_state)
        ST_RUN:  if (w_last) w_state_next = ST_DONE;
        default: w_state_next = r_state;
      endcase
    end
  end

  always_comb begin
    w_iter   = 1'b0;
    w_finish = 1'b0;
    if (!start && (r_state == ST_RUN)) begin
      w_iter   = 1'b1;
      w_finish = w_last;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count    <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_den      <= '0;
      r_dividend <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_dz       <= 1'b0;
      r_out      <= '0;
      r_rem_out  <= '0;
      r_ready    <= 1'b0;
      r_exc      <= 1'b0;
    end else if (start) begin
      r_count    <= '0;
      r_rem      <= '0;
      r_quo      <= magnitude(dividend);
      r_den      <= magnitude(divisor);
      r_dividend <= dividend;
      r_neg_q    <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      r_neg_r    <= dividend[WIDTH-1];
      r_dz       <= (divisor == '0);
      r_out      <= '0;
      r_rem_out  <= '0;
      r_ready    <= 1'b0;
      r_exc      <= 1'b0;
    end else if (w_iter) begin
      r_rem   <= w_rem_next;
      r_quo   <= w_quo_next;
      r_count <= r_count + CW'(1);
      if (w_finish) begin
        r_ready <= 1'b1;
        r_exc   <= r_dz;
        if (r_dz) begin
          r_out     <= '0;
          r_rem_out <= r_dividend;
        end else begin
          r_out     <= r_neg_q ? (~w_quo_next + 1'b1) : w_quo_next;
          r_rem_out <= r_neg_r ? (~w_rem_next + 1'b1) : w_rem_next;
        end
      end
    end
  end

  assign out       = r_out;
  assign remainder = r_rem_out;
  assign ready     = r_ready;
  assign exception = r_exc;
  assign dbg_state = r_state;

endmodule : div_unit

// File: doc/div_unit.md
Name: div_unit

Overview:
- Sequential signed 32-bit integer divider; the inverse companion of the CPU's Booth multiplier unit in the ALU execute stage.
- Takes a dividend and divisor on a start pulse and runs radix-2 restoring division on operand magnitudes, one quotient bit per cycle.
- Delivers the sign-corrected quotient and remainder with a done flag and a divide-by-zero exception.
- The pipeline stalls on !ready after issuing start.

Parameters:
- WIDTH, 32, operand/result width; iteration count equals WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; captures operands and begins a new division.
- dividend  in  WIDTH  signed two's-complement dividend, sampled only when start=1.
- divisor  in  WIDTH  signed two's-complement divisor, sampled only when start=1.
- out  out  WIDTH  signed quotient, truncated toward zero.
- remainder  out  WIDTH  signed remainder; its sign follows the dividend.
- ready  out  1  high while a completed result is held.
- exception  out  1  divide-by-zero flag, valid while ready=1.

Behaviour:
- Reset (async, any state, any time): state=IDLE, count=0, out=0, remainder=0, ready=0, exception=0, internal registers cleared. An in-flight division is discarded.
- States: IDLE, RUN, DONE.
  - IDLE --start--> RUN
  - RUN --count==WIDTH-1--> DONE
  - DONE --start--> RUN
  - Any state --start--> RUN: start has priority and restarts the operation. A start in RUN aborts the current division with no output of it.
- Capture edge E0 (start=1):
  - Latch |dividend| and |divisor| into internal registers.
  - Latch neg_q = dividend[MSB]^divisor[MSB], neg_r = dividend[MSB], dz = (divisor==0).
  - Set count=0 and ready=0.
  - out, remainder and exception drop to 0 at E0.
- Iteration edges E1..E32 (state RUN), each edge:
  - {R,Q} shift left 1.
  - trial = R - D, computed with a WIDTH+1-bit subtract.
  - If trial >= 0: R=trial and Q[0]=1; else R is unchanged and Q[0]=0.
  - count increments; transition to DONE on the edge that performs iteration WIDTH (E32).
- Latency: result is visible after E32, i.e. 32 cycles after the capture edge. ready rises in the same cycle and stays high in DONE until the next start or reset.
- Output correction, registered at E32:
  - out = neg_q ? -Q : Q
  - remainder = neg_r ? -R : R
- Divide by zero: the iterations still run, so latency is fixed. At E32: exception=1, out=0, remainder=dividend (original signed value).
- Overflow: INT_MIN / -1 returns out=0x80000000 (two's-complement wrap), remainder=0, exception=0.
- Magnitude of INT_MIN is 0x80000000 treated as unsigned; the restoring datapath is unsigned WIDTH-bit with a WIDTH+1-bit partial remainder, so no internal overflow occurs.
- start is ignored only during reset assertion. Operand inputs may change freely after E0.

Decomposition:
- Shared package (ALU defines file): state encodings IDLE/RUN/DONE, DIV_ITER = WIDTH, and the counter width $clog2(WIDTH)+1.
- Sub-module div_controller is natural: combinational single step taking R, D and the incoming Q bit, and returning next R and the quotient bit. It mirrors the multiplier's step controller.
- Top level holds the FSM, counter, operand/sign registers and output correction.

Test Plan:
- Basic: reset, then start with 100 / 7 → after exactly 32 cycles ready=1, out=14, remainder=2, exception=0. ready was 0 on cycles 1-31.
- Signs: -100/7 → out=-14, rem=-2; 100/-7 → out=-14, rem=2; -100/-7 → out=14, rem=-2.
- Divide by zero: 1234 / 0 → after 32 cycles ready=1, exception=1, out=0, remainder=1234. Then start 9/3 → exception=0, out=3.
- Boundaries:
  - 0x80000000 / -1 → out=0x80000000, rem=0, exception=0.
  - 0x80000000 / 1 → out=0x80000000.
  - 7 / 0x7FFFFFFF → out=0, rem=7.
- Restart: start 1000/10, then at cycle 10 start 81/9 → no ready before 32 cycles after the second start, then out=9, rem=0.
- Async reset mid-RUN: assert reset at cycle 15 between clock edges → ready, out, remainder and exception go to 0 immediately. No ready appears afterwards until a new start.
